xrv_mul: RTL and testbench
==========================

XRV_MUL -- requirements
Module: xrv_mul

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port multiplicand, input, 32 bits: rs1 operand, sampled only when valid=1.
REQ-004 The block SHALL have the port multiplier, input, 32 bits: rs2 operand, sampled only when valid=1.
REQ-005 The block SHALL have the port op, input, 2 bits: 00 MUL (low word), 01 MULH (signed x signed, high word), 10 MULHSU (signed rs1 x unsigned rs2, high word), 11 MULHU (unsigned x unsigned, high word); sampled only when valid=1.
REQ-006 The block SHALL have the port valid, input, 1 bit: start request, one-cycle pulse.
REQ-007 The block SHALL have the port kill, input, 1 bit: abandon the operation in flight (pipeline flush).
REQ-008 The block SHALL have the port result, output, 32 bits: selected product word.
REQ-009 The block SHALL have the port result_valid, output, 1 bit: one-cycle pulse marking result as valid.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while an operation is in flight.

Function
REQ-011 The block SHALL implement the states IDLE, CALC and DONE.
REQ-012 On valid=1 in any state, the block SHALL capture the operand magnitudes (two's-complement negation of operands that are treated as signed and negative), capture the product sign (XOR of the signed-operand MSBs; 0 for unsigned operands), capture op, clear the 64-bit accumulator and the 5-bit counter, and enter CALC.
REQ-013 In CALC, each cycle SHALL perform one radix-2 shift-add step: add the multiplicand magnitude into the accumulator upper half when the current multiplier LSB is 1, then shift right by one with the carry entering the MSB.
REQ-014 The counter SHALL increment once per CALC cycle; after the 32nd step (counter=31), the state SHALL go to DONE.
REQ-015 In DONE, the block SHALL negate the 64-bit magnitude product when the sign is 1, register result (bits [31:0] for MUL, bits [63:32] otherwise), pulse result_valid for exactly one cycle and return to IDLE.
REQ-016 Latency: for valid sampled at edge E0, result_valid SHALL be high for the cycle after edge E33; result SHALL hold its value until the next completion.
REQ-017 busy SHALL be 1 from the edge that samples valid until the edge that asserts result_valid, and 0 otherwise.
REQ-018 A valid during CALC or DONE SHALL restart the block with the new operands; the old operation SHALL produce no result_valid.
REQ-019 kill=1 SHALL force IDLE and suppress result_valid on that edge; simultaneous valid and kill SHALL resolve as kill.
REQ-020 The magnitude of 0x80000000 SHALL be the unsigned value 2^31, handled correctly without overflow; the accumulator SHALL be 64 bits plus 1 carry bit.
REQ-021 A zero operand SHALL still take the full 33-cycle latency; there SHALL be no early termination.

Reset
REQ-022 With rst=1 at an edge, the block SHALL enter IDLE with result=0, result_valid=0, busy=0 and the counter at 0.
REQ-023 rst SHALL take priority over valid and kill; reset during CALC SHALL abandon the operation with no result_valid.
REQ-024 The datapath registers (operands, accumulator) SHALL need no reset; their values SHALL not be visible on the outputs until after a completed operation.

Verification
REQ-025 The bench SHALL cover: MUL 7 x 6 -> result=0x0000002A with result_valid 33 cycles after valid, and busy high throughout.
REQ-026 The bench SHALL cover: 0xFFFFFFFF x 0xFFFFFFFF -> MUL=0x00000001, MULH=0x00000000, MULHSU=0xFFFFFFFF, MULHU=0xFFFFFFFE.
REQ-027 The bench SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0x80000000 x 0x00000002 -> 0xFFFFFFFF.
REQ-028 The bench SHALL cover: a second valid 10 cycles after the first (MUL 3 x 5, then 4 x 4) -> a single result_valid pulse, with result=0x00000010, 33 cycles after the second valid.
REQ-029 The bench SHALL cover: kill at cycle 20 of an operation -> busy=0 on the next cycle, no result_valid, and result unchanged.
REQ-030 The bench SHALL cover: rst asserted at cycle 15 -> result=0, busy=0 and no result_valid; then a fresh MUL 2 x 3 -> 0x00000006.

Source files
------------

// File: rtl/xrv_mul_if.sv
// Operand/result bundle for the iterative multiplier.
// The master drives the operands and controls; the slave returns the product word and status.
interface xrv_mul_if;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [1:0]  op;
  logic        valid;
  logic        kill;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  modport master (
    output multiplicand, multiplier, op, valid, kill,
    input  result, result_valid, busy
  );

  modport slave (
    input  multiplicand, multiplier, op, valid, kill,
    output result, result_valid, busy
  );
endinterface

// File: rtl/xrv_mul.sv
// Radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
// Multiplies operand magnitudes over 32 cycles, then applies the sign and selects a word.
module xrv_mul (
  input logic      clk,
  input logic      rst,
  xrv_mul_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] mcand_mag;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic        sign;
  logic [1:0]  op_q;

  logic        rs1_signed;
  logic        rs2_signed;
  logic        neg1;
  logic        neg2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] sum;
  logic [63:0] prod;

  // MULH treats both operands as signed, MULHSU only rs1; MUL and MULHU treat both as unsigned.
  always_comb begin
    rs1_signed = (bus.op == 2'b01) || (bus.op == 2'b10);
    rs2_signed = (bus.op == 2'b01);
    neg1       = rs1_signed && bus.multiplicand[31];
    neg2       = rs2_signed && bus.multiplier[31];
    mag1       = neg1 ? (~bus.multiplicand + 32'd1) : bus.multiplicand;
    mag2       = neg2 ? (~bus.multiplier + 32'd1) : bus.multiplier;
    sum        = {1'b0, acc[63:32]} + {1'b0, (mplier[0] ? mcand_mag : 32'd0)};
    prod       = sign ? (~acc + 64'd1) : acc;
  end

  // sum[32] is the carry bit that shifts into the accumulator MSB on each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 5'd0;
      bus.result       <= 32'd0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else if (bus.kill) begin
      state            <= IDLE;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else if (bus.valid) begin
      mcand_mag        <= mag1;
      mplier           <= mag2;
      sign             <= neg1 ^ neg2;
      op_q             <= bus.op;
      acc              <= 64'd0;
      cnt              <= 5'd0;
      state            <= CALC;
      bus.busy         <= 1'b1;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        CALC: begin
          acc    <= {sum, acc[31:1]};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          bus.result       <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
          bus.result_valid <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xrv_mul.sv
// Directed bench for xrv_mul: vector table for the arithmetic,
// hand-written sequences for restart, kill and reset mid-operation.
module tb_xrv_mul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  xrv_mul_if bus ();

  xrv_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Pulses valid across one rising edge; returns at the falling edge right after it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.op           = op;
    bus.valid        = 1'b1;
    @(negedge clk);
    bus.valid        = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, output int lat, output int pulses,
                          output int busy_low, output logic busy_at_rv, output logic [31:0] res);
    lat        = -1;
    pulses     = 0;
    busy_low   = 0;
    busy_at_rv = 1'b1;
    res        = 32'hDEADBEEF;
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat        = k;
          res        = bus.result;
          busy_at_rv = bus.busy;
        end
      end
      if (k < 33 && !bus.busy) busy_low++;
    end
  endtask

  task automatic runVector(input int idx);
    int          lat;
    int          pulses;
    int          busy_low;
    logic        busy_at_rv;
    logic [31:0] res;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(vecs[idx].a, vecs[idx].b, vecs[idx].op);
    checkOutput({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput({tag, "_result"}, res, vecs[idx].expected);
    checkOutput({tag, "_latency"}, lat, 32'd33);
    checkOutput({tag, "_pulses"}, pulses, 32'd1);
    checkOutput({tag, "_busy_low"}, busy_low, 32'd0);
    checkOutput({tag, "_busy_at_rv"}, {31'd0, busy_at_rv}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    int          busy_low;
    logic        busy_at_rv;
    logic [31:0] res;
    logic [31:0] held;
    int          early;

    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h00000007, 32'h00000006, 2'b00, 32'h0000002A};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h00000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE};
    vecs[5]  = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000};
    vecs[6]  = '{32'h80000000, 32'h00000002, 2'b10, 32'hFFFFFFFF};
    vecs[7]  = '{32'h00000000, 32'h12345678, 2'b00, 32'h00000000};
    vecs[8]  = '{32'h80000000, 32'h00000004, 2'b11, 32'h00000002};
    vecs[9]  = '{32'hFFFFFFFE, 32'h00000003, 2'b00, 32'hFFFFFFFA};
    vecs[10] = '{32'hFFFFFFFE, 32'h00000003, 2'b01, 32'hFFFFFFFF};
    vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 2'b01, 32'h3FFFFFFF};

    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    bus.op           = 2'b00;
    bus.valid        = 1'b0;
    bus.kill         = 1'b0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) runVector(i);

    // Restart: second valid 10 cycles after the first, only the second completes.
    applyStimulus(32'd3, 32'd5, 2'b00);
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.result_valid) early++;
    end
    bus.multiplicand = 32'd4;
    bus.multiplier   = 32'd4;
    bus.op           = 2'b00;
    bus.valid        = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput("restart_early_pulse", early, 32'd0);
    checkOutput("restart_pulses", pulses, 32'd1);
    checkOutput("restart_latency", lat, 32'd33);
    checkOutput("restart_result", res, 32'h00000010);

    // Kill at cycle 20: no completion and result keeps the previous value.
    held = bus.result;
    applyStimulus(32'd9, 32'd9, 2'b00);
    repeat (19) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    checkOutput("kill_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("kill_result_valid", {31'd0, bus.result_valid}, 32'd0);
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput("kill_pulses", pulses, 32'd0);
    checkOutput("kill_result_held", bus.result, held);

    // Simultaneous valid and kill resolves as kill.
    @(negedge clk);
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd5;
    bus.valid        = 1'b1;
    bus.kill         = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.kill  = 1'b0;
    checkOutput("valid_kill_busy", {31'd0, bus.busy}, 32'd0);
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput("valid_kill_pulses", pulses, 32'd0);

    // Reset at cycle 15, then a fresh operation.
    applyStimulus(32'd5, 32'd5, 2'b00);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_result", bus.result, 32'd0);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_result_valid", {31'd0, bus.result_valid}, 32'd0);
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput("midrst_pulses", pulses, 32'd0);
    applyStimulus(32'd2, 32'd3, 2'b00);
    waitDone(40, lat, pulses, busy_low, busy_at_rv, res);
    checkOutput("after_rst_result", res, 32'h00000006);
    checkOutput("after_rst_latency", lat, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
